// File: rtl/stage_latency_stats_if.sv
// Sample input and snapshot readout bundle for one stage_latency_stats instance.
// master = the stats block (drives snap_*), slave = sample producer / snapshot consumer.
interface stage_latency_stats_if #(
    parameter int WIDTH      = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int SUM_WIDTH  = 48,
    parameter int HIST_BINS  = 8,
    parameter int HIST_WIDTH = 16
);
    logic                            sample_valid;
    logic [WIDTH-1:0]                sample_cycles;
    logic                            snap_req;
    logic                            snap_clear;
    logic                            snap_valid;
    logic                            snap_ready;
    logic [CNT_WIDTH-1:0]            snap_count;
    logic [SUM_WIDTH-1:0]            snap_sum;
    logic [WIDTH-1:0]                snap_min;
    logic [WIDTH-1:0]                snap_max;
    logic                            snap_sat;
    logic [HIST_BINS*HIST_WIDTH-1:0] snap_hist;

    modport master (
        input  sample_valid, sample_cycles, snap_req, snap_clear, snap_ready,
        output snap_valid, snap_count, snap_sum, snap_min, snap_max, snap_sat, snap_hist
    );

    modport slave (
        output sample_valid, sample_cycles, snap_req, snap_clear, snap_ready,
        input  snap_valid, snap_count, snap_sum, snap_min, snap_max, snap_sat, snap_hist
    );
endinterface

// File: rtl/stage_latency_stats.sv
// Per-stage latency window (count/sum/min/max, log2 histogram when STAGE_LAT_HIST_EN); snapshot valid 1 cycle after snap_req.
// Snapshot held until snap_ready; snap_req ignored while held, live accumulation never stalls.
module stage_latency_stats #(
    parameter int WIDTH      = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int SUM_WIDTH  = 48,
    parameter int HIST_BINS  = 8,
    parameter int HIST_WIDTH = 16
) (
    input logic                   clk,
    input logic                   rst,
    stage_latency_stats_if.master bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
    state_t state, state_nxt;

    logic [CNT_WIDTH-1:0] live_count, acc_count, snap_count_r;
    logic [SUM_WIDTH-1:0] live_sum, acc_sum, snap_sum_r;
    logic [WIDTH-1:0]     live_min, acc_min, snap_min_r;
    logic [WIDTH-1:0]     live_max, acc_max, snap_max_r;
    logic                 live_sat, acc_sat, snap_sat_r, hist_ovf;
    logic [CNT_WIDTH:0]   count_inc;
    logic [SUM_WIDTH:0]   sum_inc;
    logic                 capture, clear_live;

    assign capture    = (state == IDLE) && bus.snap_req;
    assign clear_live = capture && bus.snap_clear;

    // acc_* is the window including this cycle's sample; it feeds both the live and snapshot registers
    always_comb begin
        count_inc = {1'b0, live_count} + (CNT_WIDTH+1)'(1);
        sum_inc   = {1'b0, live_sum} + (SUM_WIDTH+1)'(bus.sample_cycles);
        acc_count = live_count;
        acc_sum   = live_sum;
        acc_min   = live_min;
        acc_max   = live_max;
        acc_sat   = live_sat;
        if (bus.sample_valid) begin
            acc_count = count_inc[CNT_WIDTH] ? '1 : count_inc[CNT_WIDTH-1:0];
            acc_sum   = sum_inc[SUM_WIDTH] ? '1 : sum_inc[SUM_WIDTH-1:0];
            if (bus.sample_cycles < live_min) acc_min = bus.sample_cycles;
            if (bus.sample_cycles > live_max) acc_max = bus.sample_cycles;
            acc_sat = live_sat | count_inc[CNT_WIDTH] | sum_inc[SUM_WIDTH] | hist_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_live) begin
            live_count <= '0;
            live_sum   <= '0;
            live_min   <= '1;
            live_max   <= '0;
            live_sat   <= 1'b0;
        end else begin
            live_count <= acc_count;
            live_sum   <= acc_sum;
            live_min   <= acc_min;
            live_max   <= acc_max;
            live_sat   <= acc_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_count_r <= '0;
            snap_sum_r   <= '0;
            snap_min_r   <= '1;
            snap_max_r   <= '0;
            snap_sat_r   <= 1'b0;
        end else if (capture) begin
            snap_count_r <= acc_count;
            snap_sum_r   <= acc_sum;
            snap_min_r   <= acc_min;
            snap_max_r   <= acc_max;
            snap_sat_r   <= acc_sat;
        end
    end

    assign bus.snap_count = snap_count_r;
    assign bus.snap_sum   = snap_sum_r;
    assign bus.snap_min   = snap_min_r;
    assign bus.snap_max   = snap_max_r;
    assign bus.snap_sat   = snap_sat_r;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.snap_req)   state_nxt = HOLD;
            HOLD: if (bus.snap_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.snap_valid = (state == HOLD);
    end

`ifdef STAGE_LAT_HIST_EN
    localparam int IDX_W = $clog2(HIST_BINS);

    logic [HIST_WIDTH-1:0]           live_bin [HIST_BINS];
    logic [HIST_WIDTH-1:0]           acc_bin  [HIST_BINS];
    logic [IDX_W-1:0]                bin_idx;
    logic [HIST_BINS*HIST_WIDTH-1:0] snap_hist_r;

    // highest power of two not exceeding the sample; 0 and 1 share bin 0, top bin is open-ended
    always_comb begin
        bin_idx = '0;
        for (int k = 1; k < HIST_BINS; k++) begin
            if (bus.sample_cycles >= (WIDTH'(1) << k)) bin_idx = IDX_W'(k);
        end
    end

    always_comb begin
        hist_ovf = 1'b0;
        for (int b = 0; b < HIST_BINS; b++) begin
            acc_bin[b] = live_bin[b];
            if (bus.sample_valid && (bin_idx == IDX_W'(b))) begin
                if (&live_bin[b]) hist_ovf = 1'b1;
                else              acc_bin[b] = live_bin[b] + HIST_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < HIST_BINS; b++) begin
            if (rst || clear_live) live_bin[b] <= '0;
            else                   live_bin[b] <= acc_bin[b];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_hist_r <= '0;
        end else if (capture) begin
            for (int b = 0; b < HIST_BINS; b++) snap_hist_r[b*HIST_WIDTH +: HIST_WIDTH] <= acc_bin[b];
        end
    end

    assign bus.snap_hist = snap_hist_r;
`else
    assign hist_ovf      = 1'b0;
    assign bus.snap_hist = {(HIST_BINS*HIST_WIDTH){1'b0}};
`endif
endmodule

// File: tb/tb_stage_latency_stats.sv
// Bench for stage_latency_stats: table of sample windows plus hand sequences for same-cycle, HOLD, saturation, histogram, reset.
module tb_stage_latency_stats;
    localparam int WIDTH      = 32;
    localparam int CNT_WIDTH  = 4;
    localparam int SUM_WIDTH  = 34;
    localparam int HIST_BINS  = 8;
    localparam int HIST_WIDTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stage_latency_stats_if #(
        .WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH), .SUM_WIDTH(SUM_WIDTH),
        .HIST_BINS(HIST_BINS), .HIST_WIDTH(HIST_WIDTH)
    ) bus ();

    stage_latency_stats #(
        .WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH), .SUM_WIDTH(SUM_WIDTH),
        .HIST_BINS(HIST_BINS), .HIST_WIDTH(HIST_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [63:0] cnt;
        logic [63:0] sum;
        logic [63:0] mn;
        logic [63:0] mx;
        logic        sat;
    } snap_t;

    typedef struct {
        int          n;
        logic [31:0] s [4];
        snap_t       e;
    } vec_t;

    snap_t sb[$];
    snap_t last;
    vec_t  vt [5];
    int    checks = 0;
    int    errors = 0;

    function automatic snap_t mk(input logic [63:0] c, input logic [63:0] s,
                                 input logic [63:0] mn, input logic [63:0] mx, input logic sat);
        snap_t r;
        r.cnt = c; r.sum = s; r.mn = mn; r.mx = mx; r.sat = sat;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic sv, input logic [31:0] sc, input logic req,
                        input logic clr, input logic rdy);
        bus.sample_valid  = sv;
        bus.sample_cycles = sc;
        bus.snap_req      = req;
        bus.snap_clear    = clr;
        bus.snap_ready    = rdy;
        @(posedge clk);
        #1;
        bus.sample_valid  = 1'b0;
        bus.sample_cycles = '0;
        bus.snap_req      = 1'b0;
        bus.snap_clear    = 1'b0;
        bus.snap_ready    = 1'b0;
    endtask

    task automatic cmp_snap(input string name, input snap_t e);
        chk({name, " count"}, 64'(bus.snap_count), e.cnt);
        chk({name, " sum"},   64'(bus.snap_sum),   e.sum);
        chk({name, " min"},   64'(bus.snap_min),   e.mn);
        chk({name, " max"},   64'(bus.snap_max),   e.mx);
        chk({name, " sat"},   64'(bus.snap_sat),   64'(e.sat));
    endtask

    task automatic expect_snap(input string name);
        chk({name, " valid"}, 64'(bus.snap_valid), 64'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got snapshot expected none queued", name);
        end else begin
            last = sb.pop_front();
            cmp_snap(name, last);
        end
    endtask

    // request a snapshot with no concurrent sample and compare it one cycle later
    task automatic snap(input string name, input logic clr, input snap_t e);
        sb.push_back(e);
        step(1'b0, '0, 1'b1, clr, 1'b0);
        expect_snap(name);
    endtask

    task automatic release_snap(input string name);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk({name, " release"}, 64'(bus.snap_valid), 64'd0);
    endtask

    logic [HIST_BINS*HIST_WIDTH-1:0] hexp;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vt[0].n = 3; vt[0].s = '{32'd5, 32'd3, 32'd9, 32'd0};
        vt[0].e = mk(3, 17, 3, 9, 1'b0);
        vt[1].n = 0; vt[1].s = '{32'd0, 32'd0, 32'd0, 32'd0};
        vt[1].e = mk(0, 0, 64'hFFFF_FFFF, 0, 1'b0);
        vt[2].n = 2; vt[2].s = '{32'd0, 32'd100, 32'd0, 32'd0};
        vt[2].e = mk(2, 100, 0, 100, 1'b0);
        vt[3].n = 2; vt[3].s = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
        vt[3].e = mk(2, 64'h1_0000_0000, 1, 64'hFFFF_FFFF, 1'b0);
        vt[4].n = 1; vt[4].s = '{32'd42, 32'd0, 32'd0, 32'd0};
        vt[4].e = mk(1, 42, 42, 42, 1'b0);

        bus.sample_valid = 1'b0; bus.sample_cycles = '0; bus.snap_req = 1'b0;
        bus.snap_clear = 1'b0; bus.snap_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", 64'(bus.snap_valid), 64'd0);
        chk("reset count", 64'(bus.snap_count), 64'd0);
        chk("reset sum",   64'(bus.snap_sum),   64'd0);
        chk("reset min",   64'(bus.snap_min),   64'hFFFF_FFFF);
        chk("reset max",   64'(bus.snap_max),   64'd0);
        chk("reset sat",   64'(bus.snap_sat),   64'd0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vt[v].n; i++) step(1'b1, vt[v].s[i], 1'b0, 1'b0, 1'b0);
            snap($sformatf("vec%0d", v), 1'b1, vt[v].e);
            if (v == 0) begin
                for (int h = 0; h < 4; h++) begin
                    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
                    chk("hold valid", 64'(bus.snap_valid), 64'd1);
                    cmp_snap("hold", last);
                end
            end
            release_snap($sformatf("vec%0d", v));
        end

        // sample concurrent with a clearing capture lands in the snapshot only
        step(1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
        sb.push_back(mk(2, 9, 2, 7, 1'b0));
        step(1'b1, 32'd7, 1'b1, 1'b1, 1'b0);
        expect_snap("t3a");
        release_snap("t3a");
        step(1'b1, 32'd4, 1'b0, 1'b0, 1'b0);
        snap("t3b", 1'b0, mk(1, 4, 4, 4, 1'b0));
        release_snap("t3b");

        // window still holds {4}; req/clear during HOLD must be ignored
        snap("t4a", 1'b0, mk(1, 4, 4, 4, 1'b0));
        step(1'b1, 32'd6, 1'b1, 1'b1, 1'b0);
        chk("t4 hold valid", 64'(bus.snap_valid), 64'd1);
        cmp_snap("t4 hold", last);
        release_snap("t4a");
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("t4 idle ready", 64'(bus.snap_valid), 64'd0);
        step(1'b1, 32'd8, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
        snap("t4b", 1'b1, mk(4, 21, 3, 8, 1'b0));
        release_snap("t4b");

        for (int i = 0; i < 17; i++) step(1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
        snap("t5a", 1'b1, mk(15, 17, 1, 1, 1'b1));
        release_snap("t5a");
        step(1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
        snap("t5b", 1'b1, mk(1, 1, 1, 1, 1'b0));
        release_snap("t5b");
        for (int i = 0; i < 5; i++) step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        snap("t5c", 1'b1, mk(5, 64'h3_FFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1));
        release_snap("t5c");

        step(1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'd4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'd200, 1'b0, 1'b0, 1'b0);
        snap("t6", 1'b1, mk(5, 210, 1, 200, 1'b0));
        hexp = '0;
`ifdef STAGE_LAT_HIST_EN
        hexp[0*HIST_WIDTH +: HIST_WIDTH] = 16'd1;
        hexp[1*HIST_WIDTH +: HIST_WIDTH] = 16'd2;
        hexp[2*HIST_WIDTH +: HIST_WIDTH] = 16'd1;
        hexp[7*HIST_WIDTH +: HIST_WIDTH] = 16'd1;
`endif
        chk("t6 hist lo", bus.snap_hist[63:0],   hexp[63:0]);
        chk("t6 hist hi", bus.snap_hist[127:64], hexp[127:64]);

        // reset while holding drops the snapshot and empties the live window
        step(1'b1, 32'd50, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst hold valid", 64'(bus.snap_valid), 64'd0);
        chk("rst hold count", 64'(bus.snap_count), 64'd0);
        chk("rst hold min",   64'(bus.snap_min),   64'hFFFF_FFFF);
        snap("post rst", 1'b0, mk(0, 0, 64'hFFFF_FFFF, 0, 1'b0));
        release_snap("post rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
